// File: rtl/pipe_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit_if
// Description : ID-stage hazard/forward control bundle between the pipeline
//               and pipe_hazard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_unit_if #(
    parameter int RFIDX_WIDTH = 5,
    parameter int FW          = 3
);
    logic                   id_valid;
    logic [RFIDX_WIDTH-1:0] id_rs1;
    logic [RFIDX_WIDTH-1:0] id_rs2;
    logic                   id_use_rs1;
    logic                   id_use_rs2;
    logic                   id_regwrite;
    logic [RFIDX_WIDTH-1:0] id_rd;
    logic [1:0]             id_class;
    logic                   redirect;
    logic                   stall_if_id;
    logic                   bubble_ex;
    logic                   flush_id;
    logic                   mdu_busy;
    logic [FW-1:0]          fwd_a;
    logic [FW-1:0]          fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_regwrite, id_rd, id_class, redirect,
        input  stall_if_id, bubble_ex, flush_id, mdu_busy, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_regwrite, id_rd, id_class, redirect,
        output stall_if_id, bubble_ex, flush_id, mdu_busy, fwd_a, fwd_b
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Scoreboard-based interlock and operand-forwarding controller
//               for an in-order pipeline with NSTAGE tracked stages after ID.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int RFIDX_WIDTH = 5,
    parameter int NSTAGE      = 3,
    parameter int LOAD_LAT    = 1,
    parameter int MDU_CYCLES  = 4,
    parameter int FW          = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipe_hazard_unit_if.slave bus
);
    localparam logic [1:0] c_CLS_ALU  = 2'b00;
    localparam logic [1:0] c_CLS_LOAD = 2'b01;
    localparam logic [1:0] c_CLS_MDU  = 2'b10;
    localparam logic [3:0] c_MDU_LOAD = 4'(MDU_CYCLES - 1);

    typedef struct packed {
        logic                   valid;
        logic                   wr;
        logic [RFIDX_WIDTH-1:0] rd;
        logic [FW-1:0]          rdy;
    } entry_t;

    entry_t        r_sb [1:NSTAGE];
    logic [3:0]    r_mduCnt;
    logic [FW-1:0] r_fwdA;
    logic [FW-1:0] r_fwdB;

    logic          w_mduBusy;
    logic          w_stall;
    logic [FW-1:0] w_hitA;
    logic [FW-1:0] w_hitB;
    logic          w_waitA;
    logic          w_waitB;
    logic [FW-1:0] w_fwdA;
    logic [FW-1:0] w_fwdB;
    entry_t        w_new;

    assign w_mduBusy = (r_mduCnt != 4'd0);

    // Walk oldest to youngest so the youngest matching writer wins.
    always_comb begin
        w_hitA  = '0;
        w_hitB  = '0;
        w_waitA = 1'b0;
        w_waitB = 1'b0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (r_sb[k].valid && r_sb[k].wr && (r_sb[k].rd == bus.id_rs1)) begin
                w_hitA  = FW'(k);
                w_waitA = (r_sb[k].rdy > FW'(k));
            end
            if (r_sb[k].valid && r_sb[k].wr && (r_sb[k].rd == bus.id_rs2)) begin
                w_hitB  = FW'(k);
                w_waitB = (r_sb[k].rdy > FW'(k));
            end
        end
        if (!(bus.id_valid && bus.id_use_rs1) || (bus.id_rs1 == '0)) begin
            w_hitA  = '0;
            w_waitA = 1'b0;
        end
        if (!(bus.id_valid && bus.id_use_rs2) || (bus.id_rs2 == '0)) begin
            w_hitB  = '0;
            w_waitB = 1'b0;
        end
    end

    // The producer moves one stage along as the consumer enters stage 1;
    // a producer leaving the last stage is covered by register-file write-through.
    assign w_fwdA = ((w_hitA == '0) || (w_hitA == FW'(NSTAGE))) ? '0 : w_hitA + FW'(1);
    assign w_fwdB = ((w_hitB == '0) || (w_hitB == FW'(NSTAGE))) ? '0 : w_hitB + FW'(1);

    assign w_stall = w_waitA || w_waitB || w_mduBusy ||
                     (bus.id_valid && (bus.id_class == c_CLS_MDU) && w_mduBusy);

    always_comb begin
        w_new       = '0;
        w_new.valid = bus.id_valid;
        w_new.wr    = bus.id_regwrite && (bus.id_rd != '0);
        w_new.rd    = bus.id_rd;
        unique case (bus.id_class)
            c_CLS_ALU:  w_new.rdy = FW'(1);
            c_CLS_LOAD: w_new.rdy = FW'(1 + LOAD_LAT);
            c_CLS_MDU:  w_new.rdy = FW'(1);
            default:    w_new.rdy = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_sb[k] <= '0;
            end
            r_mduCnt <= 4'd0;
            r_fwdA   <= '0;
            r_fwdB   <= '0;
        end else begin
            for (int k = NSTAGE; k >= 3; k--) begin
                r_sb[k] <= r_sb[k-1];
            end
            if (w_mduBusy) begin
                // Stage 1 and the forward selects hold; a hole opens behind it.
                r_sb[2]  <= '0;
                r_mduCnt <= r_mduCnt - 4'd1;
            end else begin
                r_sb[2] <= r_sb[1];
                if (bus.redirect || w_stall) begin
                    r_sb[1] <= '0;
                    r_fwdA  <= '0;
                    r_fwdB  <= '0;
                end else begin
                    r_sb[1] <= w_new;
                    r_fwdA  <= w_fwdA;
                    r_fwdB  <= w_fwdB;
                    if (bus.id_valid && (bus.id_class == c_CLS_MDU) && (MDU_CYCLES > 1)) begin
                        r_mduCnt <= c_MDU_LOAD;
                    end
                end
            end
        end
    end

    assign bus.stall_if_id = w_stall;
    assign bus.bubble_ex   = w_stall;
    assign bus.flush_id    = bus.redirect;
    assign bus.mdu_busy    = w_mduBusy;
    assign bus.fwd_a       = r_fwdA;
    assign bus.fwd_b       = r_fwdB;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_unit
// Description : Directed scoreboard bench for pipe_hazard_unit in two
//               configurations (NSTAGE=3/LOAD_LAT=1 and NSTAGE=4/LOAD_LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;
    localparam int c_ALU = 0;
    localparam int c_LD  = 1;
    localparam int c_MDU = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       r_valid;
    logic [4:0] r_rs1;
    logic [4:0] r_rs2;
    logic       r_use1;
    logic       r_use2;
    logic       r_rw;
    logic [4:0] r_rd;
    logic [1:0] r_cls;
    logic       r_redir;

    int r_checks   = 0;
    int r_failures = 0;

    pipe_hazard_unit_if #(.RFIDX_WIDTH(5), .FW(3)) bus0 ();
    pipe_hazard_unit_if #(.RFIDX_WIDTH(5), .FW(3)) bus1 ();

    assign bus0.id_valid    = r_valid;
    assign bus0.id_rs1      = r_rs1;
    assign bus0.id_rs2      = r_rs2;
    assign bus0.id_use_rs1  = r_use1;
    assign bus0.id_use_rs2  = r_use2;
    assign bus0.id_regwrite = r_rw;
    assign bus0.id_rd       = r_rd;
    assign bus0.id_class    = r_cls;
    assign bus0.redirect    = r_redir;
    assign bus1.id_valid    = r_valid;
    assign bus1.id_rs1      = r_rs1;
    assign bus1.id_rs2      = r_rs2;
    assign bus1.id_use_rs1  = r_use1;
    assign bus1.id_use_rs2  = r_use2;
    assign bus1.id_regwrite = r_rw;
    assign bus1.id_rd       = r_rd;
    assign bus1.id_class    = r_cls;
    assign bus1.redirect    = r_redir;

    pipe_hazard_unit #(.RFIDX_WIDTH(5), .NSTAGE(3), .LOAD_LAT(1), .MDU_CYCLES(4), .FW(3)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    pipe_hazard_unit #(.RFIDX_WIDTH(5), .NSTAGE(4), .LOAD_LAT(2), .MDU_CYCLES(4), .FW(3)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    typedef struct {
        string      tag;
        bit         d1;
        logic       st;
        logic       fl;
        logic       bz;
        logic [2:0] fa;
        logic [2:0] fb;
    } exp_t;

    exp_t q[$];

    task automatic cmp(input string tag, input logic [2:0] got, input logic [2:0] want);
        r_checks++;
        assert (got === want) else begin
            r_failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic drive(input int v, input int cls, input int rd, input int rs1,
                         input int rs2, input int redir);
        r_valid = (v != 0);
        r_cls   = 2'(cls);
        r_rd    = 5'(rd);
        r_rs1   = 5'(rs1);
        r_rs2   = 5'(rs2);
        r_use1  = (v != 0);
        r_use2  = (v != 0);
        r_rw    = (v != 0) && (cls != 3);
        r_redir = (redir != 0);
    endtask

    task automatic push(input string tag, input int d1, input int st, input int bz,
                        input int fa, input int fb);
        exp_t e;
        e.tag = tag;
        e.d1  = (d1 != 0);
        e.st  = (st != 0);
        e.fl  = r_redir;
        e.bz  = (bz != 0);
        e.fa  = 3'(fa);
        e.fb  = 3'(fb);
        q.push_back(e);
    endtask

    task automatic popCheck();
        exp_t       e;
        logic       st, bx, fl, bz;
        logic [2:0] fa, fb;
        if (q.size() == 0) begin
            r_checks++;
            r_failures++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
            return;
        end
        e = q.pop_front();
        if (e.d1) begin
            st = bus1.stall_if_id; bx = bus1.bubble_ex; fl = bus1.flush_id;
            bz = bus1.mdu_busy;    fa = bus1.fwd_a;     fb = bus1.fwd_b;
        end else begin
            st = bus0.stall_if_id; bx = bus0.bubble_ex; fl = bus0.flush_id;
            bz = bus0.mdu_busy;    fa = bus0.fwd_a;     fb = bus0.fwd_b;
        end
        cmp({e.tag, ":stall"},  {2'b0, st}, {2'b0, e.st});
        cmp({e.tag, ":bubble"}, {2'b0, bx}, {2'b0, e.st});
        cmp({e.tag, ":flush"},  {2'b0, fl}, {2'b0, e.fl});
        cmp({e.tag, ":busy"},   {2'b0, bz}, {2'b0, e.bz});
        cmp({e.tag, ":fwd_a"},  fa, e.fa);
        cmp({e.tag, ":fwd_b"},  fb, e.fb);
        if (r_redir) begin
            r_checks++;
            assert (!bus0.mdu_busy) else begin
                r_failures++;
                $error("FAIL %s:redirect_while_busy observed=1 expected=0", e.tag);
            end
        end
    endtask

    task automatic step(input string tag, input int d1, input int v, input int cls,
                        input int rd, input int rs1, input int rs2, input int redir,
                        input int st, input int bz, input int fa, input int fb);
        @(negedge clk);
        drive(v, cls, rd, rs1, rs2, redir);
        push(tag, d1, st, bz, fa, fb);
        #1 popCheck();
    endtask

    initial begin
        reset = 1'b0;
        drive(0, c_ALU, 0, 0, 0, 0);
        step("rst",          0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 0, 0);
        reset = 1'b1;
        step("idle",         0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 0, 0);
        // back-to-back, one gap, two gaps
        step("a1",           0, 1, c_ALU,  5,  1,  2, 0,  0, 0, 0, 0);
        step("a2",           0, 1, c_ALU,  6,  5,  0, 0,  0, 0, 0, 0);
        step("b2b_fwd2",     0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 2, 0);
        step("a4",           0, 1, c_ALU,  5,  3,  4, 0,  0, 0, 0, 0);
        step("a5",           0, 1, c_ALU,  8, 10, 11, 0,  0, 0, 0, 0);
        step("a6",           0, 1, c_ALU,  9,  5,  0, 0,  0, 0, 0, 0);
        step("gap1_fwd3",    0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 3, 0);
        step("a8",           0, 1, c_ALU, 12,  0,  0, 0,  0, 0, 0, 0);
        step("a9",           0, 1, c_ALU, 13,  0,  0, 0,  0, 0, 0, 0);
        step("a10",          0, 1, c_ALU, 14,  0,  0, 0,  0, 0, 0, 0);
        step("a11",          0, 1, c_ALU, 15, 12, 13, 0,  0, 0, 0, 0);
        step("gap2_fwd0",    0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 0, 3);
        // load-use, LOAD_LAT=1
        step("ld",           0, 1, c_LD,   7,  0,  0, 0,  0, 0, 0, 0);
        step("lu_stall",     0, 1, c_ALU, 16,  7,  0, 0,  1, 0, 0, 0);
        step("lu_issue",     0, 1, c_ALU, 16,  7,  0, 0,  0, 0, 0, 0);
        step("lu_fwd3",      0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 3, 0);
        // load-use, LOAD_LAT=2, NSTAGE=4
        step("ld2",          1, 1, c_LD,  17,  0,  0, 0,  0, 0, 0, 0);
        step("lu2_stall1",   1, 1, c_ALU, 18, 17,  0, 0,  1, 0, 0, 0);
        step("lu2_stall2",   1, 1, c_ALU, 18, 17,  0, 0,  1, 0, 0, 0);
        step("lu2_issue",    1, 1, c_ALU, 18, 17,  0, 0,  0, 0, 0, 0);
        step("lu2_fwd4",     1, 0, c_ALU,  0,  0,  0, 0,  0, 0, 4, 0);
        // multi-cycle MDU
        step("mdu",          0, 1, c_MDU,  9,  0,  0, 0,  0, 0, 0, 0);
        step("mdu_busy1",    0, 1, c_ALU, 20,  9,  0, 0,  1, 1, 0, 0);
        step("mdu_busy2",    0, 1, c_ALU, 20,  9,  0, 0,  1, 1, 0, 0);
        step("mdu_busy3",    0, 1, c_ALU, 20,  9,  0, 0,  1, 1, 0, 0);
        step("mdu_release",  0, 1, c_ALU, 20,  9,  0, 0,  0, 0, 0, 0);
        step("mdu_fwd2",     0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 2, 0);
        // redirect during load-use stall, then without a stall
        step("ld3",          0, 1, c_LD,   7,  0,  0, 0,  0, 0, 0, 0);
        step("redir_stall",  0, 1, c_ALU, 21,  7,  7, 1,  1, 0, 0, 0);
        step("redir_inval",  0, 1, c_ALU, 22, 21,  7, 0,  0, 0, 0, 0);
        step("redir_issue",  0, 1, c_ALU, 23, 22,  0, 1,  0, 0, 0, 3);
        step("redir_clr",    0, 1, c_ALU, 24, 23, 22, 0,  0, 0, 0, 0);
        step("redir_adv",    0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 0, 3);
        // youngest writer and x0
        step("w4a",          0, 1, c_ALU,  4,  0,  0, 0,  0, 0, 0, 0);
        step("w4b",          0, 1, c_ALU,  4,  0,  0, 0,  0, 0, 0, 0);
        step("young",        0, 1, c_ALU, 25,  4,  4, 0,  0, 0, 0, 0);
        step("young_fwd2",   0, 1, c_LD,   0,  0,  0, 0,  0, 0, 2, 2);
        step("x0_nostall",   0, 1, c_ALU, 26,  0,  0, 0,  0, 0, 0, 0);
        step("x0_nofwd",     0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 0, 0);
        // asynchronous reset in the middle of an MDU hold
        step("mdu2",         0, 1, c_MDU, 27, 26,  0, 0,  0, 0, 0, 0);
        step("mdu2_busy1",   0, 1, c_ALU, 28,  0,  0, 0,  1, 1, 3, 0);
        step("mdu2_busy2",   0, 1, c_ALU, 28,  0,  0, 0,  1, 1, 3, 0);
        #1 reset = 1'b0;
        push("arst", 0, 0, 0, 0, 0);
        #1 popCheck();
        step("in_rst",       0, 1, c_ALU, 28,  0,  0, 0,  0, 0, 0, 0);
        reset = 1'b1;
        step("post_rst",     0, 0, c_ALU,  0,  0,  0, 0,  0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end
endmodule
`default_nettype wire
